// File: rtl/jtcontra_gfx_tilemap.sv
// Tilemap renderer for the 007121: scans VRAM, fetches 4bpp tiles from SDRAM, and renders one line ahead into a ping-pong buffer.
// Define JTCONTRA_TILEMAP_OVERRUN_EN to add overrun_cnt, which counts lines aborted by HS before they finished.
module jtcontra_gfx_tilemap #(
    parameter int HOFFSET = 0,
    parameter int TILES   = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pxl_cen,
    input  logic        LHBL,
    input  logic        HS,
    input  logic [8:0]  hdump,
    input  logic [8:0]  vrender,
    input  logic [8:0]  hpos,
    input  logic [7:0]  vpos,
    input  logic        flip,
    input  logic [2:0]  tile_bank,
    output logic [10:0] vram_addr,
    input  logic [7:0]  vram_data,
    output logic [16:0] rom_addr,
    output logic        rom_cs,
    input  logic [15:0] rom_data,
    input  logic        rom_ok,
    output logic [6:0]  pxl_out
`ifdef JTCONTRA_TILEMAP_OVERRUN_EN
    ,
    output logic [7:0]  overrun_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, ATTR, CODE, CAP, ROM0, ROM1, WRITE, NEXT} state_t;

    state_t      state;
    logic        hs_last;
    logic        hs_rise;
    logic [7:0]  hpos_l;
    logic        flip_l;
    logic [2:0]  bank_l;
    logic [7:0]  vrow;
    logic        wbank;
    logic        rbank;
    logic [5:0]  n;
    logic [7:0]  attr;
    logic        rom_skip;
    logic [15:0] word_a;
    logic [15:0] word_b;
    logic [2:0]  wcnt;

    logic [7:0]  v_start;
    logic [5:0]  n_next;
    logic [7:0]  c_next;
    logic        hflip;
    logic [2:0]  row;
    logic [31:0] pix_bits;
    logic [4:0]  pix_sh;
    logic [3:0]  nib;
    logic signed [9:0] xpos;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [7:0]  rd_col;
    logic [8:0]  rd_addr;
    logic        unused_bits;

    logic [6:0]   lbuf [0:511];
    logic [511:0] valid;

    assign hs_rise  = HS & ~hs_last;
    assign v_start  = (flip ? ~vrender[7:0] : vrender[7:0]) + vpos;
    assign n_next   = n + 6'd1;
    assign c_next   = {n_next[4:0], 3'b000} + hpos_l;
    assign hflip    = attr[5] ^ flip_l;
    assign row      = vrow[2:0] ^ {3{attr[4]}};

    // word_a is the half fetched first; under hflip that is half 1, read out nibble-reversed
    assign pix_bits = hflip ? {word_b, word_a} : {word_a, word_b};
    assign pix_sh   = hflip ? {wcnt, 2'b00} : 5'd28 - {wcnt, 2'b00};
    assign nib      = pix_bits[pix_sh +: 4];

    assign xpos     = $signed({1'b0, n, wcnt}) - $signed({7'd0, hpos_l[2:0]});
    assign wr_en    = (state == WRITE) && !xpos[9] && !xpos[8];
    assign wr_addr  = {wbank, flip_l ? ~xpos[7:0] : xpos[7:0]};
    assign rd_col   = hdump[7:0] + 8'(HOFFSET);
    assign rd_addr  = {rbank, rd_col};

    assign unused_bits = &{1'b0, hpos[8], vrender[8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hs_last   <= 1'b0;
            hpos_l    <= 8'd0;
            flip_l    <= 1'b0;
            bank_l    <= 3'd0;
            vrow      <= 8'd0;
            wbank     <= 1'b0;
            rbank     <= 1'b0;
            n         <= 6'd0;
            attr      <= 8'd0;
            rom_skip  <= 1'b0;
            word_a    <= 16'd0;
            word_b    <= 16'd0;
            wcnt      <= 3'd0;
            vram_addr <= 11'd0;
            rom_addr  <= 17'd0;
            rom_cs    <= 1'b0;
        end else begin
            hs_last <= HS;
            if (hs_rise) begin
                // A new line always wins, even over an unfinished one
                hpos_l    <= hpos[7:0];
                flip_l    <= flip;
                bank_l    <= tile_bank;
                vrow      <= v_start;
                wbank     <= vrender[0];
                rbank     <= ~vrender[0];
                n         <= 6'd0;
                vram_addr <= {1'b0, v_start[7:3], hpos[7:3]};
                rom_cs    <= 1'b0;
                state     <= ATTR;
            end else begin
                case (state)
                    IDLE: ;
                    ATTR: begin
                        vram_addr <= {1'b1, vram_addr[9:0]};
                        state     <= CODE;
                    end
                    CODE: begin
                        attr  <= vram_data;
                        state <= CAP;
                    end
                    CAP: begin
                        rom_addr <= {bank_l, attr[6], attr[7], vram_data, row, hflip};
                        rom_cs   <= 1'b1;
                        rom_skip <= 1'b1;
                        state    <= ROM0;
                    end
                    ROM0: begin
                        if (rom_skip) begin
                            rom_skip <= 1'b0;
                        end else if (rom_ok) begin
                            word_a   <= rom_data;
                            rom_addr <= {rom_addr[16:1], ~rom_addr[0]};
                            rom_skip <= 1'b1;
                            state    <= ROM1;
                        end
                    end
                    ROM1: begin
                        if (rom_skip) begin
                            rom_skip <= 1'b0;
                        end else if (rom_ok) begin
                            word_b <= rom_data;
                            rom_cs <= 1'b0;
                            wcnt   <= 3'd0;
                            state  <= WRITE;
                        end
                    end
                    WRITE: begin
                        wcnt <= wcnt + 3'd1;
                        if (wcnt == 3'd7) state <= NEXT;
                    end
                    NEXT: begin
                        n <= n_next;
                        if (n_next == 6'(TILES)) begin
                            state <= IDLE;
                        end else begin
                            vram_addr <= {1'b0, vrow[7:3], c_next[7:3]};
                            state     <= ATTR;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) lbuf[wr_addr] <= {attr[2:0], nib};
    end

    // Entries never written since reset read back as transparent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pxl_out <= 7'd0;
        end else if (pxl_cen) begin
            if (!LHBL || hdump[8]) begin
                pxl_out <= 7'd0;
            end else begin
                pxl_out <= valid[rd_addr] ? lbuf[rd_addr] : 7'd0;
            end
        end
    end

`ifdef JTCONTRA_TILEMAP_OVERRUN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_cnt <= 8'd0;
        end else if (hs_rise && state != IDLE && overrun_cnt != 8'hFF) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`endif

endmodule
